serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 112 +++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = X - Y - borrowin (mod 2^n), one bit per cycle, LSB first.
// Define SERIAL_SUBTRACTOR_CMP_EN to build the registered AeqB/AgtB compare flags.
module serial_subtractor #(
    parameter int unsigned n = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [n-1:0] X,
    input  logic [n-1:0] Y,
    input  logic         borrowin,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] D,
    output logic         borrowout,
    output logic         AeqB,
    output logic         AgtB
);

    localparam int unsigned cw = $clog2(n + 1);
    localparam logic [cw-1:0] last_cnt = cw'(n - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t          state_q;
    logic [n-1:0]    x_q, y_q, d_q;
    logic [cw-1:0]   cnt_q;
    logic            b_q, bo_q, busy_q, done_q;

    logic            d_bit, b_next, last_bit;
    logic [n-1:0]    d_next;

    always_comb begin
        d_bit    = x_q[0] ^ y_q[0] ^ b_q;
        b_next   = (~x_q[0] & y_q[0]) | (~x_q[0] & b_q) | (y_q[0] & b_q);
        d_next   = {d_bit, d_q[n-1:1]};
        last_bit = (state_q == StRun) && (cnt_q == last_cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            b_q     <= 1'b0;
            bo_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        x_q     <= X;
                        y_q     <= Y;
                        b_q     <= borrowin;
                        d_q     <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    x_q <= x_q >> 1;
                    y_q <= y_q >> 1;
                    d_q <= d_next;
                    b_q <= b_next;
                    if (last_bit) begin
                        bo_q    <= b_next;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + cw'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef SERIAL_SUBTRACTOR_CMP_EN
    logic aeqb_q, agtb_q;

    // Flags are taken from the final difference as it is written into D.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aeqb_q <= 1'b0;
            agtb_q <= 1'b0;
        end else if (last_bit) begin
            aeqb_q <= ~b_next & (d_next == '0);
            agtb_q <= ~b_next & (d_next != '0);
        end
    end

    assign AeqB = aeqb_q;
    assign AgtB = agtb_q;
`else
    assign AeqB = 1'b0;
    assign AgtB = 1'b0;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign D         = d_q;
    assign borrowout = bo_q;

endmodule
